// File: rtl/cj_pkg.sv
// Shared constants and types for the cj_tohost status register slice.
package cj_pkg;

  localparam int unsigned TOHOST_W        = 64;
  localparam int unsigned EXIT_CODE_W     = 63;
  localparam int unsigned TOHOST_DONE_BIT = 0;

  localparam logic [TOHOST_W-1:0] TOHOST_PASS    = 64'h1;
  localparam logic [TOHOST_W-1:0] TOHOST_TIMEOUT = 64'h5;

  // Source selected for the next tohost value.
  typedef enum logic [1:0] {
    SRC_HOLD    = 2'd0,
    SRC_HOST    = 2'd1,
    SRC_TIMEOUT = 2'd2
  } tohost_src_e;

  function automatic logic is_done(input logic [TOHOST_W-1:0] word);
    return word[TOHOST_DONE_BIT];
  endfunction

endpackage

// File: rtl/cj_tohost_if.sv
// Host-side signal bundle for cj_tohost: write strobe/data in, status and cycle count out.
interface cj_tohost_if
  import cj_pkg::*;
#(
  parameter int unsigned CNT_W = 64
);

  logic                host_wen;
  logic [TOHOST_W-1:0] host_wdata;
  logic [TOHOST_W-1:0] tohost;
  logic                done;
  logic [CNT_W-1:0]    cycles;

  modport master (
    output host_wen,
    output host_wdata,
    input  tohost,
    input  done,
    input  cycles
  );

  modport slave (
    input  host_wen,
    input  host_wdata,
    output tohost,
    output done,
    output cycles
  );

endinterface

// File: rtl/cj_watchdog.sv
// Saturating cycle counter with a single-cycle timeout indication.
module cj_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 150000,
  parameter int unsigned CNT_W          = 64
) (
  input  logic             clock,
  input  logic             reset,
  output logic [CNT_W-1:0] cycles,
  output logic             expire
);

  localparam bit               TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: advance by one, holding once all-ones is reached.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register, cleared by the synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Saturation stops the count from ever revisiting TO_LAST within one run.
  assign expire = TO_EN && (cnt_q == TO_LAST);
  assign cycles = cnt_q;

endmodule

// File: rtl/cj_tohost.sv
// HTIF-style tohost status register with host write, watchdog timeout and sticky finish.
module cj_tohost
  import cj_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 150000,
  parameter int unsigned CNT_W          = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                host_wen   = 1'b0,
  input  logic [TOHOST_W-1:0] host_wdata = '0,
  output logic [TOHOST_W-1:0] tohost,
  output logic                done,
  output logic [CNT_W-1:0]    cycles
);

  logic [TOHOST_W-1:0] tohost_q;
  logic [TOHOST_W-1:0] tohost_d;
  logic                expire;
  tohost_src_e         src;

  cj_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (CNT_W)
  ) u_watchdog (
    .clock  (clock),
    .reset  (reset),
    .cycles (cycles),
    .expire (expire)
  );

  // Priority: a finished word is frozen; otherwise host write beats timeout.
  always_comb begin
    src = SRC_HOLD;
    if (!is_done(tohost_q)) begin
      if (host_wen) begin
        src = SRC_HOST;
      end else if (expire) begin
        src = SRC_TIMEOUT;
      end
    end
  end

  // Next tohost value for the selected source.
  always_comb begin
    tohost_d = tohost_q;
    unique case (src)
      SRC_HOST:    tohost_d = host_wdata;
      SRC_TIMEOUT: tohost_d = TOHOST_TIMEOUT;
      default:     tohost_d = tohost_q;
    endcase
  end

  // Status register, cleared by the synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      tohost_q <= '0;
    end else begin
      tohost_q <= tohost_d;
    end
  end

  assign tohost = tohost_q;
  assign done   = is_done(tohost_q);

endmodule

// File: tb/tb_cj_tohost.sv
// Self-checking bench for cj_tohost: directed scenarios plus randomized traffic
// against a behavioural model, on two instances (timeout 16 / 64-bit counter,
// and timeout disabled / 5-bit counter).
module tb_cj_tohost;
  import cj_pkg::*;

  localparam int unsigned TO_A = 16;
  localparam int unsigned CW_A = 64;
  localparam int unsigned TO_B = 0;
  localparam int unsigned CW_B = 5;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        drv_wen;
  logic [63:0] drv_wdata;

  cj_tohost_if #(.CNT_W(CW_A)) ifa ();
  cj_tohost_if #(.CNT_W(CW_B)) ifb ();

  assign ifa.host_wen   = drv_wen;
  assign ifa.host_wdata = drv_wdata;
  assign ifb.host_wen   = drv_wen;
  assign ifb.host_wdata = drv_wdata;

  cj_tohost #(.TIMEOUT_CYCLES(TO_A), .CNT_W(CW_A)) dut_a (
    .clock      (clock),
    .reset      (reset),
    .host_wen   (ifa.host_wen),
    .host_wdata (ifa.host_wdata),
    .tohost     (ifa.tohost),
    .done       (ifa.done),
    .cycles     (ifa.cycles)
  );

  cj_tohost #(.TIMEOUT_CYCLES(TO_B), .CNT_W(CW_B)) dut_b (
    .clock      (clock),
    .reset      (reset),
    .host_wen   (ifb.host_wen),
    .host_wdata (ifb.host_wdata),
    .tohost     (ifb.tohost),
    .done       (ifb.done),
    .cycles     (ifb.cycles)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Reference state, index 0 = dut_a, 1 = dut_b.
  logic [63:0] m_toh [2];
  logic [63:0] m_cyc [2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance the reference by one clock edge using the currently driven inputs.
  task automatic model_edge();
    longint unsigned tmo;
    logic [63:0]     cmax;
    for (int i = 0; i < 2; i++) begin
      tmo  = (i == 0) ? longint'(TO_A) : longint'(TO_B);
      cmax = (i == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'(2 ** CW_B - 1);
      if (!reset) begin
        m_toh[i] = 64'h0;
        m_cyc[i] = 64'h0;
      end else begin
        if (m_toh[i][0] == 1'b0) begin
          if (drv_wen)
            m_toh[i] = drv_wdata;
          else if (tmo != 0 && m_cyc[i] == tmo - 1)
            m_toh[i] = 64'h5;
        end
        if (m_cyc[i] < cmax) m_cyc[i] = m_cyc[i] + 1;
      end
    end
  endtask

  // One clock: update model at the edge, compare all outputs 1 time unit later.
  task automatic tick(input string tag);
    @(posedge clock);
    model_edge();
    #1;
    check({tag, "/a.tohost"}, ifa.tohost, m_toh[0]);
    check({tag, "/a.done"},   64'(ifa.done), 64'(m_toh[0][0]));
    check({tag, "/a.cycles"}, ifa.cycles, m_cyc[0]);
    check({tag, "/b.tohost"}, ifb.tohost, m_toh[1]);
    check({tag, "/b.done"},   64'(ifb.done), 64'(m_toh[1][0]));
    check({tag, "/b.cycles"}, 64'(ifb.cycles), m_cyc[1]);
  endtask

  task automatic run_to_cycle(input string tag, input logic [63:0] target);
    for (int k = 0; k < 64 && m_cyc[0] != target; k++) tick(tag);
    check({tag, "/reach"}, ifa.cycles, target);
  endtask

  initial begin
    m_toh[0] = '0; m_toh[1] = '0;
    m_cyc[0] = '0; m_cyc[1] = '0;
    reset     = 1'b0;
    drv_wen   = 1'b1;
    drv_wdata = 64'h1;

    // Reset held with a finishing write pending.
    for (int k = 0; k < 5; k++) begin
      tick("rst");
      check("rst.tohost", ifa.tohost, 64'h0);
      check("rst.done",   64'(ifa.done), 64'h0);
      check("rst.cycles", ifa.cycles, 64'h0);
    end

    // Finish at cycle 10, later write 0x3 ignored.
    reset = 1'b1; drv_wen = 1'b0; drv_wdata = 64'h0;
    run_to_cycle("pass", 64'd10);
    drv_wen = 1'b1; drv_wdata = 64'h1;
    tick("pass.w1");
    check("pass.tohost", ifa.tohost, 64'h1);
    check("pass.done",   64'(ifa.done), 64'h1);
    drv_wen = 1'b0;
    tick("pass.idle");
    drv_wen = 1'b1; drv_wdata = 64'h3;
    tick("pass.w3");
    check("sticky.tohost", ifa.tohost, 64'h1);
    drv_wen = 1'b0;

    // Non-finishing write followed by finishing write.
    reset = 1'b0;
    tick("r2");
    check("r2.cycles", ifa.cycles, 64'h0);
    reset = 1'b1;
    tick("r2.run"); tick("r2.run");
    drv_wen = 1'b1; drv_wdata = 64'h4;
    tick("w4");
    check("w4.tohost", ifa.tohost, 64'h4);
    check("w4.done",   64'(ifa.done), 64'h0);
    drv_wdata = 64'h7;
    tick("w7");
    check("w7.tohost", ifa.tohost, 64'h7);
    check("w7.done",   64'(ifa.done), 64'h1);
    drv_wen = 1'b0;

    // Timeout with no writes; counter keeps running.
    reset = 1'b0;
    tick("r3");
    reset = 1'b1;
    run_to_cycle("to", 64'd15);
    check("to.pre", ifa.tohost, 64'h0);
    tick("to.edge");
    check("to.tohost", ifa.tohost, 64'h5);
    check("to.cycles", ifa.cycles, 64'd16);
    check("to.b",      ifb.tohost, 64'h0);
    tick("to.17");
    check("to.c17", ifa.cycles, 64'd17);
    tick("to.18");
    check("to.c18",    ifa.cycles, 64'd18);
    check("to.hold",   ifa.tohost, 64'h5);
    for (int k = 0; k < 20; k++) tick("sat");
    check("sat.b", 64'(ifb.cycles), 64'd31);

    // One-cycle reset after done, then time out again.
    reset = 1'b0;
    tick("r4");
    check("r4.tohost", ifa.tohost, 64'h0);
    check("r4.cycles", ifa.cycles, 64'h0);
    reset = 1'b1;
    run_to_cycle("to2", 64'd15);
    tick("to2.edge");
    check("to2.tohost", ifa.tohost, 64'h5);

    // Host write in the timeout cycle wins.
    reset = 1'b0;
    tick("r5");
    reset = 1'b1;
    run_to_cycle("race", 64'd15);
    drv_wen = 1'b1; drv_wdata = 64'h1;
    tick("race.edge");
    check("race.tohost", ifa.tohost, 64'h1);
    drv_wen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick("race.hold");
      check("race.hold", ifa.tohost, 64'h1);
    end

    // Randomized traffic: sparse writes, occasional resets, garbage data when idle.
    for (int k = 0; k < 600; k++) begin
      reset     = ($urandom_range(0, 49) != 0);
      drv_wen   = ($urandom_range(0, 9) == 0);
      drv_wdata = {$urandom, $urandom};
      if (drv_wen && $urandom_range(0, 2) != 0) drv_wdata[0] = 1'b0;
      tick("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cj_tohost.md
CJ_TOHOST -- requirements
Module: cj_tohost

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 150000, cycles after reset release before a self-declared timeout; 0 disables the timeout.
REQ-002 Parameter CNT_W, default 64, width of the internal cycle counter.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  reset, synchronous, active-low.
REQ-005 host_wen  input  1  host/co-simulation write strobe; declared with port default value 0.
REQ-006 host_wdata  input  64  value written to tohost when host_wen=1; port default 0.
REQ-007 tohost  output  64  HTIF-style status word: bit0=1 finished, bits[63:1]=exit code (0 pass).
REQ-008 done  output  1  equals tohost[0].
REQ-009 cycles  output  CNT_W  cycles elapsed since reset release, saturating.

Function
REQ-010 tohost SHALL be a register; every update is visible the cycle after the causing edge (1-cycle latency).
REQ-011 While tohost[0]=0 and host_wen=1, tohost SHALL load host_wdata at the next edge.
REQ-012 A write with bit0=0 (e.g. 0x4) SHALL update tohost without finishing; a later write may still finish.
REQ-013 Once tohost[0]=1, tohost SHALL be sticky: further host writes and timeouts are ignored until reset.
REQ-014 cycles SHALL increment by 1 each edge out of reset and saturate at all-ones.
REQ-015 When TIMEOUT_CYCLES!=0, tohost[0]=0 and cycles==TIMEOUT_CYCLES-1, tohost SHALL load 5 (exit code 2 = timeout) at that edge.
REQ-016 Simultaneous host write and timeout in one cycle: host write SHALL win.
REQ-017 The counter SHALL keep counting after done; it does not re-trigger the timeout.
REQ-018 done SHALL be combinational from tohost[0]; no other combinational input-to-output paths.
REQ-019 X on host_wdata while host_wen=0 SHALL NOT affect tohost.

Reset
REQ-020 While reset=0 at a rising edge: tohost<=0, cycles<=0, hence done=0.
REQ-021 Reset asserted mid-run (including after done) SHALL fully clear state; counting restarts on the first edge with reset=1.
REQ-022 No state SHALL depend on initial values; all registers covered by reset.

Structure
REQ-023 Package cj_pkg SHALL hold TOHOST_PASS=64'h1, TOHOST_TIMEOUT=64'h5, TOHOST_DONE_BIT=0 and the exit-code field width (63).
REQ-024 One sub-module cj_watchdog SHALL implement the saturating counter and the timeout pulse (ports clock, reset, cycles, expire).
REQ-025 Top level holds only the tohost register, write/timeout priority mux and sticky logic.

Verification
REQ-026 Hold reset=0 for 5 cycles with host_wen=1, host_wdata=1 -> tohost=0, done=0, cycles=0 throughout.
REQ-027 Release reset; at cycle 10 pulse host_wen with 0x1 -> tohost=0x1, done=1 one cycle later; at cycle 12 write 0x3 -> tohost stays 0x1.
REQ-028 Write 0x4 then 0x7 on consecutive cycles -> tohost 0x4 then 0x7, done rises only with 0x7.
REQ-029 TIMEOUT_CYCLES=16, no writes -> tohost=0x5 after edge at cycles==15; cycles continues to 17, 18, ... with tohost held at 5.
REQ-030 TIMEOUT_CYCLES=16, host write 0x1 in the timeout cycle -> tohost=0x1 (write wins), never 0x5.
REQ-031 After done, assert reset=0 for 1 cycle -> tohost=0, cycles=0; next run times out again at cycle 15.
